// File: rtl/bus_rr_arbiter_pkg.sv
// Shared definitions for the four-requester round-robin bus arbiter.
// Holds the state encoding, the requester count and width, and the default hold limit.
// Also provides the one-hot helper used when a winner is registered.
package bus_rr_arbiter_pkg;

  localparam int NUM_REQ      = 4;
  localparam int ID_W         = 2;
  localparam int MAX_HOLD_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_TURN  = 2'd2
  } arb_state_e;

  // Encoded requester index -> one-hot grant vector
  function automatic logic [NUM_REQ-1:0] id_to_onehot(input logic [ID_W-1:0] id);
    logic [NUM_REQ-1:0] oh;
    oh = '0;
    oh[id] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/bus_rr_arbiter_if.sv
// Request/grant bundle between the requesters and the arbiter.
// Pure wiring, no latency; grants are registered inside the arbiter.
// No backpressure: requests are level-sensitive and held until granted.
interface bus_rr_arbiter_if;
  import bus_rr_arbiter_pkg::*;

  logic               arb_enable;
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_id;
  logic               grant_valid;
  logic               hold_timeout;

  // Requester side: drives requests and the global enable
  modport master (
    output arb_enable, req,
    input  grant, grant_id, grant_valid, hold_timeout
  );

  // Arbiter side: samples requests and drives the grant outputs
  modport slave (
    input  arb_enable, req,
    output grant, grant_id, grant_valid, hold_timeout
  );

endinterface

// File: rtl/bus_rr_arbiter_rr_pick.sv
// Round-robin winner search starting one past the previous owner.
// Purely combinational, zero latency.
// No backpressure; found=0 when no request bit is set.
module rr_pick
  import bus_rr_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last,
  output logic               found,
  output logic [ID_W-1:0]    winner_id
);

  logic [ID_W-1:0] idx;

  // Scan from the farthest candidate down to last+1 so the nearest requester wins
  always_comb begin
    found     = 1'b0;
    winner_id = '0;
    idx       = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      // k == NUM_REQ truncates to offset 0, i.e. the previous owner ranks last
      idx = last + ID_W'(k);
      if (req[idx]) begin
        found     = 1'b1;
        winner_id = idx;
      end
    end
  end

endmodule

// File: rtl/bus_rr_arbiter.sv
// Four-requester round-robin arbiter with hold limit and one idle turnaround cycle.
// Latency: req sampled at edge N gives a registered grant from edge N+1.
// No backpressure: owner keeps the bus while requesting, up to MAX_HOLD cycles.
module bus_rr_arbiter
  import bus_rr_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEF,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  bus_rr_arbiter_if.slave  bus
);

  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  arb_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ID_W-1:0]    last_q, last_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [ID_W-1:0]    grant_id_q, grant_id_d;
  logic               grant_valid_q, grant_valid_d;
  logic               hold_timeout_q, hold_timeout_d;

  logic               pick_found;
  logic [ID_W-1:0]    pick_id;

  rr_pick u_rr_pick (
    .req       (bus.req),
    .last      (last_q),
    .found     (pick_found),
    .winner_id (pick_id)
  );

  // Next-state and registered-output computation
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    last_d         = last_q;
    grant_d        = grant_q;
    grant_id_d     = grant_id_q;
    grant_valid_d  = grant_valid_q;
    hold_timeout_d = 1'b0;

    case (state_q)
      // IDLE and the single TURN cycle arbitrate identically
      ST_IDLE, ST_TURN: begin
        if (bus.arb_enable && pick_found) begin
          state_d       = ST_GRANT;
          grant_d       = id_to_onehot(pick_id);
          grant_id_d    = pick_id;
          grant_valid_d = 1'b1;
          cnt_d         = CNT_W'(1);
          last_d        = pick_id;
        end else begin
          state_d       = ST_IDLE;
          grant_d       = '0;
          grant_id_d    = '0;
          grant_valid_d = 1'b0;
          cnt_d         = '0;
        end
      end

      ST_GRANT: begin
        if (!bus.req[grant_id_q] || (cnt_q >= HOLD_LIM)) begin
          // Release takes precedence over timeout when both occur together
          state_d        = ST_TURN;
          grant_d        = '0;
          grant_id_d     = '0;
          grant_valid_d  = 1'b0;
          cnt_d          = '0;
          hold_timeout_d = bus.req[grant_id_q];
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d       = ST_IDLE;
        grant_d       = '0;
        grant_id_d    = '0;
        grant_valid_d = 1'b0;
        cnt_d         = '0;
      end
    endcase
  end

  // State, counter, pointer and output registers; reset points priority at requester 0
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      last_q         <= ID_W'(NUM_REQ - 1);
      grant_q        <= '0;
      grant_id_q     <= '0;
      grant_valid_q  <= 1'b0;
      hold_timeout_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      last_q         <= last_d;
      grant_q        <= grant_d;
      grant_id_q     <= grant_id_d;
      grant_valid_q  <= grant_valid_d;
      hold_timeout_q <= hold_timeout_d;
    end
  end

  assign bus.grant        = grant_q;
  assign bus.grant_id     = grant_id_q;
  assign bus.grant_valid  = grant_valid_q;
  assign bus.hold_timeout = hold_timeout_q;

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Bench for bus_rr_arbiter: directed scenarios plus random traffic against a behavioural model.
// Inputs change 1 time unit after the rising edge; outputs are checked at the same point.
// The model tracks owner / cycles held / last owner with plain integers.
module tb_bus_rr_arbiter;

  localparam int MAXH = 4;

  logic clk;
  logic reset_n;

  bus_rr_arbiter_if bus ();

  bus_rr_arbiter #(.MAX_HOLD(MAXH), .CNT_W(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: -1 means no owner
  int m_owner;
  int m_held;
  int m_last;
  int m_to;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_held  = 0;
    m_last  = 3;
    m_to    = 0;
  endtask

  task automatic model_edge(input logic [3:0] r, input logic e);
    int idx;
    m_to = 0;
    if (m_owner >= 0) begin
      if (!r[m_owner]) begin
        m_owner = -1;
      end else if (m_held >= MAXH) begin
        m_owner = -1;
        m_to    = 1;
      end else begin
        m_held++;
      end
    end else if (e && (r != 4'b0000)) begin
      for (int k = 1; k <= 4; k++) begin
        idx = (m_last + k) % 4;
        if (r[idx] && (m_owner < 0)) m_owner = idx;
      end
      m_last = m_owner;
      m_held = 1;
    end
  endtask

  task automatic check_model();
    logic [3:0] eg;
    logic [1:0] ei;
    eg = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
    ei = (m_owner >= 0) ? 2'(m_owner) : 2'b00;
    chk("grant",        8'(bus.grant),        8'(eg));
    chk("grant_id",     8'(bus.grant_id),     8'(ei));
    chk("grant_valid",  8'(bus.grant_valid),  8'(m_owner >= 0));
    chk("hold_timeout", 8'(bus.hold_timeout), 8'(m_to));
    chk("onehot0",      8'($onehot0(bus.grant)), 8'd1);
  endtask

  task automatic step(input logic [3:0] r, input logic e);
    bus.req        = r;
    bus.arb_enable = e;
    @(posedge clk);
    model_edge(r, e);
    #1;
    check_model();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_grant"},   8'(bus.grant),        8'd0);
    chk({tag, "_id"},      8'(bus.grant_id),     8'd0);
    chk({tag, "_valid"},   8'(bus.grant_valid),  8'd0);
    chk({tag, "_timeout"}, 8'(bus.hold_timeout), 8'd0);
  endtask

  initial begin
    logic [3:0] r;
    logic       e;
    logic [3:0] eg;

    // Reset held with all requesters active
    reset_n        = 1'b0;
    bus.req        = 4'b1111;
    bus.arb_enable = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;

    // All four requesting: owners 0,1,2,3,0 for MAXH cycles each, one idle cycle with timeout pulse between
    for (int i = 0; i < 5 * (MAXH + 1); i++) begin
      step(4'b1111, 1'b1);
      if ((i % (MAXH + 1)) < MAXH) begin
        eg = 4'(1 << ((i / (MAXH + 1)) % 4));
        chk("rr_seq_grant", 8'(bus.grant), 8'(eg));
        chk("rr_seq_to", 8'(bus.hold_timeout), 8'd0);
      end else begin
        chk("rr_seq_gap_grant", 8'(bus.grant), 8'd0);
        chk("rr_seq_gap_to", 8'(bus.hold_timeout), 8'd1);
      end
    end
    chk("post_reset_first_owner_last", 8'(m_last), 8'd0);

    // Drain to IDLE
    repeat (3) step(4'b0000, 1'b1);

    // Short pulse on requester 2: three grant cycles, then release without timeout
    for (int i = 0; i < 3; i++) begin
      step(4'b0100, 1'b1);
      chk("pulse_grant", 8'(bus.grant), 8'h04);
    end
    step(4'b0000, 1'b1);
    check_zero("pulse_release");
    step(4'b0000, 1'b1);
    check_zero("pulse_idle");

    // Requester 1 alone held: MAXH grants, one gap with timeout, then re-granted
    for (int i = 0; i < 2 * (MAXH + 1); i++) begin
      step(4'b0010, 1'b1);
      if ((i % (MAXH + 1)) < MAXH) chk("solo_grant", 8'(bus.grant), 8'h02);
      else                         chk("solo_gap_to", 8'(bus.hold_timeout), 8'd1);
    end
    repeat (3) step(4'b0000, 1'b1);

    // Make requester 0 the last owner so requester 1 wins next
    step(4'b0001, 1'b1);
    chk("en_setup_grant0", 8'(bus.grant), 8'h01);
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);
    step(4'b1111, 1'b1);
    chk("en_owner1", 8'(bus.grant), 8'h02);
    // Enable drops: owner 1 keeps running, others ignored
    step(4'b1111, 1'b0);
    step(4'b1111, 1'b0);
    chk("en_owner1_kept", 8'(bus.grant), 8'h02);
    step(4'b1101, 1'b0);
    check_zero("en_release");
    repeat (3) begin
      step(4'b1101, 1'b0);
      check_zero("en_parked");
    end
    step(4'b1101, 1'b1);
    chk("en_resume_grant", 8'(bus.grant), 8'h04);
    chk("en_resume_id", 8'(bus.grant_id), 8'd2);

    // Asynchronous reset in the middle of an ownership
    step(4'b1101, 1'b1);
    #3;
    reset_n = 1'b0;
    #1;
    check_zero("async_reset");
    #1;
    reset_n = 1'b1;
    model_reset();
    step(4'b1111, 1'b1);
    chk("async_restart_grant", 8'(bus.grant), 8'h01);
    chk("async_restart_valid", 8'(bus.grant_valid), 8'd1);

    // Random traffic: requests tend to persist, enable mostly high
    r = 4'b0000;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
      e = ($urandom_range(0, 7) != 0);
      step(r, e);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
